dec_scan_n: RTL
===============

Name: dec_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a valid/ready output stage.
- Adds an auto-scan mode: an internal counter walks the active bit across all outputs at a programmable rate.
- Used for row/column select and peripheral chip-select sequencing, where the decoded pattern must be held until the consumer takes it.

Parameters:
- N, 3, select width; output width is 2^N (derived localparam OUT_W).
- SCAN_DIV, 4, clock cycles per scan step (legal range 1..65535); divider counter width is $clog2(SCAN_DIV+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 freezes all state.
- mode  in  1  0 = decode, 1 = scan.
- i  in  N  select value (decode mode).
- in_valid  in  1  i is valid.
- in_ready  out  1  block can accept i.
- y  out  OUT_W  registered one-hot output.
- out_valid  out  1  y holds an untaken pattern.
- out_ready  in  1  consumer takes y.
- idx  out  N  index of the active bit in y.
- wrap  out  1  one-cycle pulse when scan index wraps from 2^N-1 to 0.

Behaviour:
- Reset (rst=1 at a clk edge, overriding everything, including mid-scan or a pending output):
  - y=0, idx=0, out_valid=0, wrap=0, divider=0, state=S_DEC.
  - in_ready is combinational and reads 0 while rst=1.
- State machine:
  - S_DEC: decode mode.
  - S_SCAN_WAIT: divider counting down.
  - S_SCAN_OUT: step presented, waiting for transfer.
- Output transfer: out_valid && out_ready. out_valid stays high and y/idx stay stable until transfer; never retract.
- S_DEC:
  - in_ready = en && !mode && (!out_valid || out_ready).
  - Accept on in_valid && in_ready. Next cycle: y = 1<<i, idx=i, out_valid=1. Latency 1 clock.
  - Back-to-back: acceptance and transfer in the same cycle keeps out_valid=1 with the new pattern, giving full throughput.
  - Transfer without a new acceptance clears out_valid; y keeps its last value.
- Mode switch:
  - Sampled only when out_valid=0, or in the cycle of a transfer. A pending output is always drained first.
  - S_DEC with mode=1 goes to S_SCAN_WAIT, divider loaded with SCAN_DIV-1, idx unchanged.
  - From either scan state, mode=0 goes to S_DEC.
- S_SCAN_WAIT:
  - in_ready=0.
  - Divider decrements each enabled cycle.
  - When it reaches 0: idx <= idx+1 (mod 2^N), y <= 1<<(idx+1), out_valid=1, go to S_SCAN_OUT.
  - wrap=1 for exactly that cycle if idx was 2^N-1.
- S_SCAN_OUT: on transfer, reload the divider with SCAN_DIV-1 and go to S_SCAN_WAIT. Consumer back-pressure stalls the scan; steps are never skipped.
- SCAN_DIV=1: one step every cycle while out_ready=1, i.e. one output change per clock.
- en=0:
  - No acceptance, divider frozen, state frozen, wrap=0.
  - out_valid, y and idx hold, and a transfer may still complete.
- Width rules:
  - i is always in range, so there is no default/illegal branch.
  - y is never all-zero while out_valid=1.

Optional Feature:
- Macro: DEC_ACT_LOW_EN.
- Defined: y is driven inverted, i.e. one-cold; the reset value of y is all ones. All handshake, idx and wrap behaviour is unchanged.
- Undefined: one-hot active-high y with reset value 0.

Decomposition:
- Package dec_scan_pkg holds:
  - the state enum type (S_DEC, S_SCAN_WAIT, S_SCAN_OUT);
  - MODE_DEC/MODE_SCAN constants;
  - a function onehot(idx) returning a 2^N-bit pattern, parametrised through the module.
- One natural sub-module: dec_onehot_core, a combinational N-to-2^N decoder. It is instantiated once, and its output is muxed into the y register.
- The handshake register and the FSM stay in the top module.

Test Plan:
- Reset then decode, N=3: mode=0, out_ready=1, i=5 with in_valid for 1 cycle -> next cycle y=8'b0010_0000, idx=5, out_valid=1; cycle after that out_valid=0.
- Back-pressure: out_ready=0, send i=2, then hold i=6 valid -> y stays 8'b0000_0100, in_ready=0. After out_ready=1: i=6 accepted, y=8'b0100_0000 one cycle later, no drop or duplicate.
- Scan, SCAN_DIV=4, out_ready=1, start idx=0 -> idx steps 1,2,...,7,0 every 5 cycles (4 wait + 1 out). wrap=1 only on the 7->0 step; y always has exactly one bit set.
- Scan stall: out_ready=0 at idx=3 for 20 cycles -> y=8'b0000_1000 held, idx does not advance. Release -> next step idx=4 after 4 cycles.
- en=0 mid-scan for 10 cycles -> divider and idx frozen, wrap=0. On resume, remaining wait count continues unchanged.
- rst=1 mid-scan with out_valid=1 -> next cycle y=0 (all ones under DEC_ACT_LOW_EN), idx=0, out_valid=0, state S_DEC, in_ready=1 once rst=0 and mode=0.

Source files
------------

// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared types and helpers for the dec_scan_n decoder/scanner.
//   state_t   : FSM encoding (decode / scan wait / scan output)
//   MODE_*    : values of the mode input
//   onehot()  : MAX_N-bit index -> MAX_OUT_W-bit one-hot; callers cast
//               the result down to their own 2^N output width.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    S_DEC       = 2'd0,
    S_SCAN_WAIT = 2'd1,
    S_SCAN_OUT  = 2'd2
  } state_t;

  localparam logic MODE_DEC  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // Widest select the helper supports; N above this is not supported.
  localparam int MAX_N     = 8;
  localparam int MAX_OUT_W = 1 << MAX_N;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_N-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/dec_onehot_core.sv
// dec_onehot_core: purely combinational N -> 2^N one-hot decoder.
//   sel : N-bit index (always in range, no illegal values)
//   y   : 2^N-bit pattern with only bit sel set
module dec_onehot_core
  import dec_scan_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   y
);

  assign y = (1<<N)'(onehot(MAX_N'(sel)));

endmodule

// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N one-hot decoder with a valid/ready output
// stage and an auto-scan mode that walks the active bit across all outputs.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   en                : global enable; 0 freezes divider/state/acceptance
//   mode              : 0 = decode i, 1 = scan
//   i, in_valid       : select input and its valid
//   in_ready          : combinational, accept i this cycle
//   y                 : registered decoded pattern
//   out_valid         : y holds a pattern not yet taken
//   out_ready         : consumer takes y
//   idx               : index of the active bit of y
//   wrap              : one-cycle pulse on the scan step 2^N-1 -> 0
//
// Build option: define DEC_ACT_LOW_EN to drive y one-cold (reset all ones).
module dec_scan_n
  import dec_scan_pkg::*;
#(
  parameter  int N        = 3,
  parameter  int SCAN_DIV = 4,
  localparam int OUT_W    = 1 << N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     idx,
  output logic             wrap
);

  localparam int          DW     = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DIV_LD = DW'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [N-1:0]     idx_q, idx_d, idx_inc, sel;
  logic [OUT_W-1:0] hot_q, hot_d, dec;
  logic             ov_q, ov_d, wrap_q, wrap_d;
  logic             xfer, slot_free, accept;

  assign idx_inc   = idx_q + N'(1);
  assign xfer      = ov_q && out_ready;
  // Output register is free now or frees at this edge.
  assign slot_free = !ov_q || out_ready;
  assign in_ready  = !rst && en && (state_q == S_DEC) && (mode == MODE_DEC) && slot_free;
  assign accept    = in_valid && in_ready;

  // Single decoder: decode mode feeds i, scan feeds the next index.
  assign sel = (state_q == S_DEC) ? i : idx_inc;

  dec_onehot_core #(.N(N)) u_core (
    .sel (sel),
    .y   (dec)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    hot_d   = hot_q;
    ov_d    = ov_q && !xfer;   // a transfer may complete even with en=0
    wrap_d  = 1'b0;
    unique case (state_q)
      S_DEC: begin
        if (accept) begin
          hot_d = dec;
          idx_d = i;
          ov_d  = 1'b1;
        end else if (en && slot_free && mode == MODE_SCAN) begin
          state_d = S_SCAN_WAIT;
          div_d   = DIV_LD;
        end
      end
      S_SCAN_WAIT: begin
        if (en) begin
          if (slot_free && mode == MODE_DEC) begin
            state_d = S_DEC;
          end else if (div_q == '0) begin
            hot_d   = dec;
            idx_d   = idx_inc;
            ov_d    = 1'b1;
            wrap_d  = (idx_q == '1);
            state_d = S_SCAN_OUT;
          end else begin
            div_d = div_q - DW'(1);
          end
        end
      end
      S_SCAN_OUT: begin
        // !ov_q here means the step was taken while en=0; move on now.
        if (en && slot_free) begin
          if (mode == MODE_DEC) begin
            state_d = S_DEC;
          end else if (SCAN_DIV == 1) begin
            // No wait phase: present the next step in the transfer cycle
            // so the output changes every clock.
            hot_d  = dec;
            idx_d  = idx_inc;
            ov_d   = 1'b1;
            wrap_d = (idx_q == '1);
          end else begin
            state_d = S_SCAN_WAIT;
            div_d   = DIV_LD;
          end
        end
      end
      default: state_d = S_DEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DEC;
      div_q   <= '0;
      idx_q   <= '0;
      hot_q   <= '0;
      ov_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      hot_q   <= hot_d;
      ov_q    <= ov_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef DEC_ACT_LOW_EN
  assign y = ~hot_q;
`else
  assign y = hot_q;
`endif

  assign out_valid = ov_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule
